pcpi_issue_master: RTL
======================

// Module: pcpi_issue_master
// PURPOSE
//  Initiator side of the PCPI coprocessor interface. It accepts one instruction with its
//  operands on a valid/ready command port, then drives pcpi_valid/insn/rs1/rs2 toward a
//  coprocessor such as the PCPI multiplier. It waits for pcpi_ready or a timeout and returns
//  result, write flag, error and latency on a valid/ready response port. One transaction in flight.
// PARAMETERS
//  TIMEOUT   16  cycles without pcpi_wait/pcpi_ready before the insn is declared unclaimed (>=2)
//  LAT_W     16  width of latency counter rsp_cycles
// PORTS
//  clk          in   1   clock, all logic on rising edge
//  resetn       in   1   asynchronous active-low reset
//  cmd_valid    in   1   command offered
//  cmd_ready    out  1   command accepted when cmd_valid&&cmd_ready
//  cmd_insn     in   32  instruction word
//  cmd_rs1      in   32  operand 1
//  cmd_rs2      in   32  operand 2
//  pcpi_valid   out  1   PCPI request strobe
//  pcpi_insn    out  32  latched instruction
//  pcpi_rs1     out  32  latched operand 1
//  pcpi_rs2     out  32  latched operand 2
//  pcpi_wr      in   1   coprocessor writes rd
//  pcpi_rd      in   32  coprocessor result
//  pcpi_wait    in   1   coprocessor claims insn, still busy
//  pcpi_ready   in   1   coprocessor done, rd/wr valid this cycle
//  rsp_valid    out  1   response available
//  rsp_ready    in   1   response consumed when rsp_valid&&rsp_ready
//  rsp_rd       out  32  captured pcpi_rd (0 on error)
//  rsp_wr       out  1   captured pcpi_wr (0 on error)
//  rsp_err      out  1   1 = timeout, insn unclaimed
//  rsp_cycles   out  LAT_W  cycles pcpi_valid was high, saturating
// BEHAVIOUR
//  - Reset: state IDLE. All outputs 0 except cmd_ready. cmd_ready is combinational (state==IDLE),
//    so it is 1 once resetn is high. Reset mid-transaction drops pcpi_valid immediately with no response.
//  - All outputs are registered, except cmd_ready.
//  - FSM IDLE -> ISSUE -> RESP -> IDLE.
//  - IDLE: on accept, latch insn/rs1/rs2 into pcpi_*. Next cycle pcpi_valid=1, tcnt=0, lat=1.
//  - ISSUE: pcpi_valid and pcpi_insn/rs1/rs2 held stable. Each cycle, in priority order:
//    1. pcpi_ready=1: capture rd/wr, rsp_err=0, pcpi_valid<=0, go to RESP. Ready wins over timeout.
//    2. pcpi_wait=1: tcnt<=0. No upper bound while wait is held.
//    3. else tcnt++. When tcnt reaches TIMEOUT-1: rsp_err=1, rsp_rd=0, rsp_wr=0, pcpi_valid<=0, go to RESP.
//       With no claim, pcpi_valid is high exactly TIMEOUT cycles.
//  - lat increments each ISSUE cycle and saturates at 2^LAT_W-1. rsp_cycles<=lat on the exit transition.
//  - RESP: rsp_valid=1; rsp_* stable until rsp_ready. On handshake: rsp_valid<=0, go to IDLE.
//    Earliest next command is accepted the following cycle (no overlap).
//  - Min latency: accept at cycle 0, pcpi_valid high at 1, ready at 1, rsp_valid at 2, rsp_cycles=1.
//  - pcpi_ready/pcpi_wait are ignored outside ISSUE. A stray ready pulse in IDLE/RESP has no effect.
//  - cmd_valid is ignored while not IDLE; cmd_* need not be held after accept.
// TESTING
//  1. MUL insn 32'h0200_0033, rs1=3, rs2=7, multiplier model ready after 5 cycles:
//     rsp_rd=21, rsp_wr=1, rsp_err=0, rsp_cycles=6 (ready in the 6th pcpi_valid cycle).
//  2. MULHU insn 32'h0200_3033, rs1=rs2=32'hFFFFFFFF:
//     rsp_rd=32'hFFFFFFFE, rsp_err=0; pcpi_rs1/rs2 stable for the whole ISSUE phase.
//  3. Unresponsive coprocessor (wait=ready=0): pcpi_valid high exactly 16 cycles,
//     rsp_err=1, rsp_rd=0, rsp_wr=0, rsp_cycles=16.
//  4. pcpi_wait held 40 cycles, then ready with rd=32'h1234_5678: no timeout,
//     rsp_rd=32'h1234_5678, rsp_cycles=41. Also ready and timeout on the same cycle -> rsp_err=0.
//  5. rsp_ready low 5 cycles: rsp_* stable, cmd_ready=0, new cmd_valid not accepted.
//     rsp_ready=1 -> cmd_ready=1 the next cycle.
//  6. resetn pulsed low mid-ISSUE: pcpi_valid=0 and rsp_valid=0 asynchronously,
//     no response emitted, next command completes normally.

Source files
------------

// File: rtl/pcpi_issue_master_if.sv
// Signal bundle between a PCPI issue master, its command source, the coprocessor and the response sink.
// The master modport is the issue master's view; slave is the environment's view.
interface pcpi_issue_master_if #(
    parameter int LAT_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [31:0]       cmd_insn;
    logic [31:0]       cmd_rs1;
    logic [31:0]       cmd_rs2;

    logic              pcpi_valid;
    logic [31:0]       pcpi_insn;
    logic [31:0]       pcpi_rs1;
    logic [31:0]       pcpi_rs2;
    logic              pcpi_wr;
    logic [31:0]       pcpi_rd;
    logic              pcpi_wait;
    logic              pcpi_ready;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rd;
    logic              rsp_wr;
    logic              rsp_err;
    logic [LAT_W-1:0]  rsp_cycles;

    modport master (
        input  cmd_valid,
        input  cmd_insn,
        input  cmd_rs1,
        input  cmd_rs2,
        output cmd_ready,
        output pcpi_valid,
        output pcpi_insn,
        output pcpi_rs1,
        output pcpi_rs2,
        input  pcpi_wr,
        input  pcpi_rd,
        input  pcpi_wait,
        input  pcpi_ready,
        output rsp_valid,
        output rsp_rd,
        output rsp_wr,
        output rsp_err,
        output rsp_cycles,
        input  rsp_ready
    );

    modport slave (
        output cmd_valid,
        output cmd_insn,
        output cmd_rs1,
        output cmd_rs2,
        input  cmd_ready,
        input  pcpi_valid,
        input  pcpi_insn,
        input  pcpi_rs1,
        input  pcpi_rs2,
        output pcpi_wr,
        output pcpi_rd,
        output pcpi_wait,
        output pcpi_ready,
        input  rsp_valid,
        input  rsp_rd,
        input  rsp_wr,
        input  rsp_err,
        input  rsp_cycles,
        output rsp_ready
    );
endinterface

// File: rtl/pcpi_issue_master.sv
// PCPI initiator: takes one instruction on the command port, issues it to a coprocessor,
// and reports result, write flag, timeout error and latency on the response port.
module pcpi_issue_master #(
    parameter int TIMEOUT = 16,
    parameter int LAT_W   = 16
) (
    input  logic                clk,
    input  logic                resetn,
    pcpi_issue_master_if.master bus
);
    localparam int                  TCNT_W    = $clog2(TIMEOUT);
    localparam logic [TCNT_W-1:0]   TCNT_LAST = TCNT_W'(TIMEOUT - 1);
    localparam logic [LAT_W-1:0]    LAT_MAX   = {LAT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t              state_reg;
    state_t              state_next;

    logic [TCNT_W-1:0]   tcnt_reg;
    logic [TCNT_W-1:0]   tcnt_next;
    logic [LAT_W-1:0]    lat_reg;
    logic [LAT_W-1:0]    lat_next;

    logic                pcpi_valid_reg;
    logic                pcpi_valid_next;
    logic [31:0]         insn_reg;
    logic [31:0]         insn_next;
    logic [31:0]         rs1_reg;
    logic [31:0]         rs1_next;
    logic [31:0]         rs2_reg;
    logic [31:0]         rs2_next;

    logic                rsp_valid_reg;
    logic                rsp_valid_next;
    logic [31:0]         rsp_rd_reg;
    logic [31:0]         rsp_rd_next;
    logic                rsp_wr_reg;
    logic                rsp_wr_next;
    logic                rsp_err_reg;
    logic                rsp_err_next;
    logic [LAT_W-1:0]    rsp_cycles_reg;
    logic [LAT_W-1:0]    rsp_cycles_next;

    logic                cmd_fire;
    logic                rsp_fire;
    logic                issue_done;
    logic                issue_timeout;

    assign cmd_fire      = (state_reg == S_IDLE) && bus.cmd_valid;
    assign rsp_fire      = (state_reg == S_RESP) && bus.rsp_ready;
    assign issue_done    = (state_reg == S_ISSUE) && bus.pcpi_ready;
    // Ready takes priority, and wait restarts the count, so timeout only fires on an idle coprocessor.
    assign issue_timeout = (state_reg == S_ISSUE) && !bus.pcpi_ready && !bus.pcpi_wait
                           && (tcnt_reg == TCNT_LAST);

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (cmd_fire) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue_done || issue_timeout) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_fire) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Output logic: next values of every registered output and the counters
    always_comb begin
        tcnt_next       = tcnt_reg;
        lat_next        = lat_reg;
        pcpi_valid_next = pcpi_valid_reg;
        insn_next       = insn_reg;
        rs1_next        = rs1_reg;
        rs2_next        = rs2_reg;
        rsp_valid_next  = rsp_valid_reg;
        rsp_rd_next     = rsp_rd_reg;
        rsp_wr_next     = rsp_wr_reg;
        rsp_err_next    = rsp_err_reg;
        rsp_cycles_next = rsp_cycles_reg;

        case (state_reg)
            S_IDLE: begin
                if (cmd_fire) begin
                    insn_next       = bus.cmd_insn;
                    rs1_next        = bus.cmd_rs1;
                    rs2_next        = bus.cmd_rs2;
                    pcpi_valid_next = 1'b1;
                    tcnt_next       = '0;
                    lat_next        = LAT_W'(1);
                end
            end
            S_ISSUE: begin
                if (lat_reg != LAT_MAX) begin
                    lat_next = lat_reg + LAT_W'(1);
                end
                if (issue_done) begin
                    pcpi_valid_next = 1'b0;
                    rsp_valid_next  = 1'b1;
                    rsp_rd_next     = bus.pcpi_rd;
                    rsp_wr_next     = bus.pcpi_wr;
                    rsp_err_next    = 1'b0;
                    rsp_cycles_next = lat_reg;
                end else if (bus.pcpi_wait) begin
                    tcnt_next = '0;
                end else if (issue_timeout) begin
                    pcpi_valid_next = 1'b0;
                    rsp_valid_next  = 1'b1;
                    rsp_rd_next     = '0;
                    rsp_wr_next     = 1'b0;
                    rsp_err_next    = 1'b1;
                    rsp_cycles_next = lat_reg;
                end else begin
                    tcnt_next = tcnt_reg + TCNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_fire) begin
                    rsp_valid_next = 1'b0;
                end
            end
            default: begin
                pcpi_valid_next = 1'b0;
                rsp_valid_next  = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tcnt_reg       <= '0;
            lat_reg        <= '0;
            pcpi_valid_reg <= 1'b0;
            insn_reg       <= '0;
            rs1_reg        <= '0;
            rs2_reg        <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_rd_reg     <= '0;
            rsp_wr_reg     <= 1'b0;
            rsp_err_reg    <= 1'b0;
            rsp_cycles_reg <= '0;
        end else begin
            tcnt_reg       <= tcnt_next;
            lat_reg        <= lat_next;
            pcpi_valid_reg <= pcpi_valid_next;
            insn_reg       <= insn_next;
            rs1_reg        <= rs1_next;
            rs2_reg        <= rs2_next;
            rsp_valid_reg  <= rsp_valid_next;
            rsp_rd_reg     <= rsp_rd_next;
            rsp_wr_reg     <= rsp_wr_next;
            rsp_err_reg    <= rsp_err_next;
            rsp_cycles_reg <= rsp_cycles_next;
        end
    end

    assign bus.cmd_ready  = (state_reg == S_IDLE);
    assign bus.pcpi_valid = pcpi_valid_reg;
    assign bus.pcpi_insn  = insn_reg;
    assign bus.pcpi_rs1   = rs1_reg;
    assign bus.pcpi_rs2   = rs2_reg;
    assign bus.rsp_valid  = rsp_valid_reg;
    assign bus.rsp_rd     = rsp_rd_reg;
    assign bus.rsp_wr     = rsp_wr_reg;
    assign bus.rsp_err    = rsp_err_reg;
    assign bus.rsp_cycles = rsp_cycles_reg;

endmodule
